kmap_sweep_ctrl: RTL and testbench

- Sequencer for the shared 4-input combinational function unit (x[4:1] -> f).
- On a start request it drives x through a programmable, possibly wrapping, range at one point per cycle and samples f in the same cycle.
- It builds a 16-bit truth mask and a ones count, and can optionally stop early at the first x where f is 1.
- It sits between the test/config logic and the function unit; it is the only driver of the unit's x input.

---
 rtl/kmap_sweep_ctrl.sv | 126 ++++++++++++
 tb/tb_kmap_sweep_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/kmap_sweep_ctrl.sv
// rtl/kmap_sweep_ctrl.sv - sweep sequencer for the shared 4-input function unit
module kmap_sweep_ctrl #(
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [3:0]  lo_i,
  input  logic [3:0]  hi_i,
  input  logic        stop_on_one_i,
  output logic [3:0]  fx_o,
  input  logic        ff_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] mask_o,
  output logic [4:0]  ones_o,
  output logic        hit_o,
  output logic [3:0]  hit_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cur_q, cur_d;
  logic [3:0]  hi_q, hi_d;
  logic        stop_q, stop_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  ones_q, ones_d;
  logic        hit_q, hit_d;
  logic [3:0]  hit_idx_q, hit_idx_d;
  logic        last_pt;

  // State and result registers; reset clears everything, even mid-sweep
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cur_q     <= 4'd0;
      hi_q      <= 4'd0;
      stop_q    <= 1'b0;
      mask_q    <= 16'd0;
      ones_q    <= 5'd0;
      hit_q     <= 1'b0;
      hit_idx_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      hi_q      <= hi_d;
      stop_q    <= stop_d;
      mask_q    <= mask_d;
      ones_q    <= ones_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  // Next-state: start acceptance, one evaluation per RUN cycle, abort handling
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    hi_d      = hi_q;
    stop_d    = stop_q;
    mask_d    = mask_q;
    ones_d    = ones_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    // Early stop only counts when enabled; the hi boundary always ends the sweep
    last_pt   = (cur_q == hi_q) || (stop_q && ff_i);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !abort_i) begin
          state_d   = S_RUN;
          cur_d     = lo_i;
          hi_d      = hi_i;
          stop_d    = stop_on_one_i;
          mask_d    = 16'd0;
          ones_d    = 5'd0;
          hit_d     = 1'b0;
          hit_idx_d = 4'd0;
        end else if (state_q == S_DONE && !HOLD_DONE) begin
          // Pulse mode: DONE lasts a single cycle, results stay put
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          mask_d    = 16'd0;
          ones_d    = 5'd0;
          hit_d     = 1'b0;
          hit_idx_d = 4'd0;
        end else begin
          mask_d[cur_q] = ff_i;
          ones_d        = ones_q + {4'd0, ff_i};
          if (last_pt) begin
            state_d = S_DONE;
            if (stop_q && ff_i) begin
              hit_d     = 1'b1;
              hit_idx_d = cur_q;
            end
          end else begin
            cur_d = cur_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: x is only driven to the unit while a sweep is running
  always_comb begin
    fx_o      = (state_q == S_RUN) ? cur_q : 4'd0;
    busy_o    = (state_q == S_RUN);
    done_o    = (state_q == S_DONE);
    mask_o    = mask_q;
    ones_o    = ones_q;
    hit_o     = hit_q;
    hit_idx_o = hit_idx_q;
  end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb/tb_kmap_sweep_ctrl.sv - directed bench for kmap_sweep_ctrl
module tb_kmap_sweep_ctrl;

  // Function unit table: f=1 at x = 0,1,4,5,6,12,14,15
  localparam logic [15:0] FTAB = 16'hD073;

  logic        clk = 1'b0;
  logic        reset_i, start_i, abort_i, stop_on_one_i;
  logic [3:0]  lo_i, hi_i;

  logic [3:0]  fx1, fx0;
  logic        ff1, ff0;
  logic        busy1, busy0, done1, done0, hit1, hit0;
  logic [15:0] mask1, mask0;
  logic [4:0]  ones1, ones0;
  logic [3:0]  idx1, idx0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ff1 = FTAB[fx1];
  assign ff0 = FTAB[fx0];

  kmap_sweep_ctrl #(.HOLD_DONE(1'b1)) u_dut_hold (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .lo_i(lo_i), .hi_i(hi_i), .stop_on_one_i(stop_on_one_i),
    .fx_o(fx1), .ff_i(ff1), .busy_o(busy1), .done_o(done1),
    .mask_o(mask1), .ones_o(ones1), .hit_o(hit1), .hit_idx_o(idx1)
  );

  kmap_sweep_ctrl #(.HOLD_DONE(1'b0)) u_dut_pulse (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .lo_i(lo_i), .hi_i(hi_i), .stop_on_one_i(stop_on_one_i),
    .fx_o(fx0), .ff_i(ff0), .busy_o(busy0), .done_o(done0),
    .mask_o(mask0), .ones_o(ones0), .hit_o(hit0), .hit_idx_o(idx0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic [3:0] lo, input logic [3:0] hi, input logic stop,
                           input int exp_n, input logic [15:0] exp_mask, input int exp_ones,
                           input logic exp_hit, input logic [3:0] exp_idx, input logic hold_start);
    int n;
    logic [3:0] e;
    @(negedge clk);
    lo_i = lo; hi_i = hi; stop_on_one_i = stop; start_i = 1'b1;
    @(negedge clk);
    if (!hold_start) start_i = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      e = lo + 4'(n);
      chk("fx_seq", 32'(fx1), 32'(e));
      n++;
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("busy_cycles", 32'(n), 32'(exp_n));
    chk("done_rise", 32'(done1), 1);
    chk("fx_idle", 32'(fx1), 0);
    chk("mask", 32'(mask1), 32'(exp_mask));
    chk("ones", 32'(ones1), 32'(exp_ones));
    chk("hit", 32'(hit1), 32'(exp_hit));
    chk("hit_idx", 32'(idx1), 32'(exp_idx));
  endtask

  initial begin
    int n;
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; stop_on_one_i = 1'b0;
    lo_i = 4'd0; hi_i = 4'd0;
    @(negedge clk); @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_fx", 32'(fx1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_mask", 32'(mask1), 0);
    chk("rst_ones", 32'(ones1), 0);
    chk("rst_hit", 32'(hit1), 0);
    chk("rst_idx", 32'(idx1), 0);

    // Full sweep
    run_sweep(4'd0, 4'd15, 1'b0, 16, 16'hD073, 8, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("done_held", 32'(done1), 1);
    chk("mask_held", 32'(mask1), 32'h0000D073);

    // Wrapping range
    run_sweep(4'd14, 4'd1, 1'b0, 4, 16'hC003, 4, 1'b0, 4'd0, 1'b0);
    // Early stop at 12
    run_sweep(4'd7, 4'd2, 1'b1, 6, 16'h1000, 1, 1'b1, 4'd12, 1'b0);
    // All-zero window
    run_sweep(4'd7, 4'd11, 1'b0, 5, 16'h0000, 0, 1'b0, 4'd0, 1'b0);
    // Single point
    run_sweep(4'd5, 4'd5, 1'b0, 1, 16'h0020, 1, 1'b0, 4'd0, 1'b0);

    // Abort during the 3rd cycle of a full sweep
    @(negedge clk);
    lo_i = 4'd0; hi_i = 4'd15; stop_on_one_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk); abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_mask", 32'(mask1), 0);
    chk("abort_ones", 32'(ones1), 0);
    chk("abort_fx", 32'(fx1), 0);
    @(negedge clk); @(negedge clk);
    chk("abort_no_done", 32'(done1), 0);

    // Reset during the 3rd cycle of a full sweep
    start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    chk("mid_mask_nonzero", 32'(mask1), 32'h00000001);
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    chk("mrst_busy", 32'(busy1), 0);
    chk("mrst_done", 32'(done1), 0);
    chk("mrst_mask", 32'(mask1), 0);
    chk("mrst_ones", 32'(ones1), 0);
    chk("mrst_fx", 32'(fx1), 0);
    chk("mrst_hit", 32'(hit1), 0);

    // Same-cycle start and abort in IDLE: nothing starts
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    chk("sa_busy", 32'(busy1), 0);
    @(negedge clk);
    chk("sa_busy2", 32'(busy1), 0);
    chk("sa_done", 32'(done1), 0);
    chk("sa_mask", 32'(mask1), 0);

    // start held high through RUN: same results as a single pulse
    run_sweep(4'd0, 4'd15, 1'b0, 16, 16'hD073, 8, 1'b0, 4'd0, 1'b1);

    // Pulse-mode done on the HOLD_DONE=0 instance
    @(negedge clk);
    lo_i = 4'd5; hi_i = 4'd5; stop_on_one_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("p_cycles", 32'(n), 1);
    chk("p_done_hi", 32'(done0), 1);
    @(negedge clk);
    chk("p_done_lo", 32'(done0), 0);
    chk("p_busy", 32'(busy0), 0);
    chk("p_mask", 32'(mask0), 32'h00000020);
    chk("p_ones", 32'(ones0), 1);
    @(negedge clk);
    chk("p_done_lo2", 32'(done0), 0);
    chk("h_done_still", 32'(done1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
